instr_fetch_responder: RTL and testbench

INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

---
 rtl/instr_fetch_responder.sv | 115 +++++++++++
 tb/tb_instr_fetch_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: one synchronous-read stage feeding a 2-entry
// response FIFO, with a program-load write port into the instruction memory.
module instr_fetch_responder #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_pc_o,
    output logic [31:0] rsp_instr_o,
    output logic [1:0]  rsp_err_o,
    input  logic        load_en_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] mem_q [MEM_DEPTH];
    logic [31:0] rdata_q;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_pc_q, s1_pc_d;
    logic [1:0]  s1_err_q, s1_err_d;

    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_instr_q [2];
    logic [1:0]  fifo_err_q   [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        accept;
    logic        pop;
    logic        push;
    logic [1:0]  req_err;
    logic [2:0]  occupancy;
    logic        load_in_range;
    logic        unused_load_lsb;

    assign req_err       = {|req_addr_i[31:AW+2], |req_addr_i[1:0]};
    assign load_in_range = ~|load_addr_i[31:AW+2];
    assign unused_load_lsb = ^load_addr_i[1:0];

    assign rsp_valid_o = (count_q != 2'd0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign push        = s1_valid_q;

    // Entries held after this edge if nothing new were accepted.
    assign occupancy   = {1'b0, count_q} + {2'b00, s1_valid_q} - {2'b00, pop};
    assign req_ready_o = !rst && ((occupancy < 3'd2) || flush_i);
    assign accept      = req_valid_i && req_ready_o;

    // Read-first memory; errored fetches never touch the array.
    always_ff @(posedge clk) begin
        if (accept && (req_err == 2'b00)) begin
            rdata_q <= mem_q[req_addr_i[AW+1:2]];
        end
        if (load_en_i && load_in_range) begin
            mem_q[load_addr_i[AW+1:2]] <= load_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= s1_pc_q;
            fifo_instr_q[wr_ptr_q] <= (s1_err_q != 2'b00) ? NOP_INSTR : rdata_q;
            fifo_err_q[wr_ptr_q]   <= s1_err_q;
        end
    end

    always_comb begin
        s1_valid_d = accept;
        s1_pc_d    = accept ? req_addr_i : s1_pc_q;
        s1_err_d   = accept ? req_err : s1_err_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        // A redirect empties the buffer but keeps a request accepted alongside it.
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            s1_err_q   <= '0;
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pc_q    <= s1_pc_d;
            s1_err_q   <= s1_err_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    assign rsp_pc_o    = rsp_valid_o ? fifo_pc_q[rd_ptr_q]    : 32'd0;
    assign rsp_instr_o = rsp_valid_o ? fifo_instr_q[rd_ptr_q] : 32'd0;
    assign rsp_err_o   = rsp_valid_o ? fifo_err_q[rd_ptr_q]   : 2'b00;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder: queue-based occupancy model checked every
// cycle, plus literal expectations per directed scenario.
module tb_instr_fetch_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_pc_o;
    logic [31:0] rsp_instr_o;
    logic [1:0]  rsp_err_o;
    logic        load_en_i = 1'b0;
    logic [31:0] load_addr_i = '0;
    logic [31:0] load_data_i = '0;

    instr_fetch_responder #(.MEM_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_pc_o(rsp_pc_o), .rsp_instr_o(rsp_instr_o), .rsp_err_o(rsp_err_o),
        .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  err;
        int          cyc;
    } ent_t;

    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    ent_t        q_m[$];
    ent_t        got[$];
    logic [31:0] mem_m [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: every accepted fetch is one queue entry, visible two cycles later.
    int   occ;
    bit   vis, pop_m, rdy_m, acc_m;
    ent_t e;
    always @(negedge clk) begin
        if (rst) begin
            check("rst_ready", req_ready_o, 0);
            check("rst_valid", rsp_valid_o, 0);
            check("rst_pc", rsp_pc_o, 0);
            check("rst_instr", rsp_instr_o, 0);
            check("rst_err", rsp_err_o, 0);
            q_m.delete();
        end else begin
            occ   = q_m.size();
            vis   = (occ > 0) && (q_m[0].cyc <= cyc);
            pop_m = vis && rsp_ready_i;
            rdy_m = ((occ - int'(pop_m)) < 2) || flush_i;
            check("ready", req_ready_o, rdy_m);
            check("valid", rsp_valid_o, vis);
            if (vis) begin
                check("pc", rsp_pc_o, q_m[0].pc);
                check("instr", rsp_instr_o, q_m[0].instr);
                check("err", rsp_err_o, q_m[0].err);
            end
            if (rsp_valid_o && rsp_ready_i) begin
                e.pc = rsp_pc_o; e.instr = rsp_instr_o; e.err = rsp_err_o; e.cyc = cyc;
                got.push_back(e);
            end
            acc_m = req_valid_i && rdy_m;
            if (flush_i) q_m.delete();
            else if (pop_m) void'(q_m.pop_front());
            if (acc_m) begin
                e.pc     = req_addr_i;
                e.err[0] = (req_addr_i[1:0] != 2'b00);
                e.err[1] = (req_addr_i[31:2] >= DEPTH);
                e.instr  = (e.err != 2'b00) ? NOP : mem_m[req_addr_i[31:2]];
                e.cyc    = cyc + 2;
                q_m.push_back(e);
            end
            if (load_en_i && (load_addr_i[31:2] < DEPTH)) mem_m[load_addr_i[31:2]] = load_data_i;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en_i = 1'b1; load_addr_i = a; load_data_i = d;
        step();
        load_en_i = 1'b0;
    endtask

    // Leaves req_valid_i high so successive calls stream back to back.
    task automatic send(input logic [31:0] a, output int acc);
        bit ok;
        ok = 0;
        acc = -1;
        req_valid_i = 1'b1;
        req_addr_i = a;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = req_ready_o;
            step();
        end
        if (ok) acc = cyc - 1;
        else begin
            n_vec++; n_fail++;
            $display("FAIL send_timeout: addr %h never accepted", a);
        end
    endtask

    int acc0, a;

    initial begin
        repeat (2) step();
        rst = 1'b0;
        #1 check("ready_after_reset", req_ready_o, 1);
        step();
        for (int i = 0; i < 4; i++) load(32'(i * 4), 32'hA0 + 32'(i));
        load(32'h40, 32'hC0);

        // In-order streaming, one response per cycle
        rsp_ready_i = 1'b1;
        got.delete();
        send(32'h0, acc0); send(32'h4, a); send(32'h8, a); send(32'hC, a);
        req_valid_i = 1'b0;
        repeat (5) step();
        check("stream_count", got.size(), 4);
        if (got.size() == 4) begin
            check("stream_latency", got[0].cyc, acc0 + 2);
            for (int i = 0; i < 4; i++) begin
                check("stream_pc", got[i].pc, 32'(i * 4));
                check("stream_instr", got[i].instr, 32'hA0 + 32'(i));
                check("stream_err", got[i].err, 0);
                check("stream_rate", got[i].cyc, got[0].cyc + i);
            end
        end

        // Backpressure for five cycles
        rsp_ready_i = 1'b0;
        got.delete();
        fork
            begin
                send(32'h0, a); send(32'h4, a); send(32'h8, a); send(32'hC, a);
                req_valid_i = 1'b0;
            end
            begin
                repeat (5) step();
                rsp_ready_i = 1'b1;
            end
        join
        repeat (6) step();
        check("stall_count", got.size(), 4);
        if (got.size() == 4)
            for (int i = 0; i < 4; i++) check("stall_pc", got[i].pc, 32'(i * 4));

        // Error responses
        got.delete();
        send(32'h2, a); send(32'h1000, a); send(32'h1002, a);
        req_valid_i = 1'b0;
        repeat (5) step();
        check("err_count", got.size(), 3);
        if (got.size() == 3) begin
            check("err_misaligned", got[0].err, 2'b01);
            check("err_range", got[1].err, 2'b10);
            check("err_both", got[2].err, 2'b11);
            for (int i = 0; i < 3; i++) check("err_nop", got[i].instr, 32'h13);
        end

        // Flush with two buffered fetches and a redirect in the same cycle
        rsp_ready_i = 1'b0;
        send(32'h0, a); send(32'h4, a);
        req_valid_i = 1'b0;
        step(); step();
        got.delete();
        flush_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 32'h40;
        step();
        flush_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        check("valid_after_flush", rsp_valid_o, 0);
        step();
        check("redirect_valid", rsp_valid_o, 1);
        check("redirect_pc", rsp_pc_o, 32'h40);
        repeat (3) step();
        check("flush_count", got.size(), 1);
        if (got.size() == 1) check("flush_instr", got[0].instr, 32'hC0);

        // Read-first on a same-cycle load, then a misaligned load address
        got.delete();
        load_en_i = 1'b1; load_addr_i = 32'h8; load_data_i = 32'hDEAD_BEEF;
        send(32'h8, a);
        load_en_i = 1'b0;
        send(32'h8, a);
        req_valid_i = 1'b0;
        load(32'hD, 32'hB3);
        send(32'hC, a);
        req_valid_i = 1'b0;
        repeat (4) step();
        check("rf_count", got.size(), 3);
        if (got.size() == 3) begin
            check("rf_old", got[0].instr, 32'hA2);
            check("rf_new", got[1].instr, 32'hDEAD_BEEF);
            check("load_lsb_ignored", got[2].instr, 32'hB3);
        end

        // Asynchronous reset with one fetch in the FIFO and one in s1
        rsp_ready_i = 1'b0;
        send(32'h0, a); send(32'h4, a);
        req_valid_i = 1'b0;
        got.delete();
        #1 check("valid_before_rst", rsp_valid_o, 1);
        #1 rst = 1'b1;
        #1 check("async_rst_valid", rsp_valid_o, 0);
        check("async_rst_pc", rsp_pc_o, 0);
        check("async_rst_instr", rsp_instr_o, 0);
        step(); step();
        rst = 1'b0;
        rsp_ready_i = 1'b1;
        repeat (5) step();
        check("no_rsp_after_rst", got.size(), 0);
        send(32'h0, a);
        req_valid_i = 1'b0;
        repeat (4) step();
        check("mem_kept_count", got.size(), 1);
        if (got.size() == 1) check("mem_kept", got[0].instr, 32'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
